// File: rtl/i2s_pkg.sv
// Shared constants and state encodings for the I2S transmitter.
// Slot/frame geometry is fixed by the I2S framing; sample width is a module parameter.
package i2s_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRIME_REQ = 2'd1,
    PRIME_CAP = 2'd2,
    RUN       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_CAP  = 2'd2
  } fetch_t;

endpackage

// File: rtl/i2s_clkgen.sv
// BCLK generator: divider counter plus bclk register, with one-cycle tick
// strobes on the clk edge where bclk rises/falls. clear holds bclk low.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int            CW   = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(BCLK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          bclk_r;
  logic          term_s;

  assign term_s    = (cnt_r == TERM) && !clear;
  assign rise_tick = term_s && !bclk_r;
  assign fall_tick = term_s && bclk_r;
  assign bclk      = bclk_r;

  // divider count and bclk toggle at terminal count
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_r  <= '0;
      bclk_r <= 1'b0;
    end else if (term_s) begin
      cnt_r  <= '0;
      bclk_r <= ~bclk_r;
    end else begin
      cnt_r  <= cnt_r + 1'b1;
      bclk_r <= bclk_r;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: primes a hold register from the sample FIFO, then streams
// 64-bit frames (left slot, right slot) MSB-first while prefetching the next word.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = 24,
  parameter int BCLK_DIV    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [2*SAMPLE_BITS-1:0] sample_in,
  input  logic                     sample_empty,
  output logic                     sample_rd,
  output logic                     bclk,
  output logic                     lrclk,
  output logic                     sdata,
  output logic                     underrun
);

  localparam int BCW = $clog2(FRAME_BITS);
  localparam int WW  = 2 * SAMPLE_BITS;

  state_t                 state_r, state_s;
  fetch_t                 fetch_r, fetch_s;
  logic [BCW-1:0]         bit_cnt_r, bit_cnt_s;
  logic [FRAME_BITS-1:0]  shift_r, shift_s;
  logic [WW-1:0]          hold_r, hold_s;
  logic [WW-1:0]          cap_word_s;
  logic                   zero_r, zero_s;
  logic                   lrclk_r, lrclk_s;
  logic                   sample_rd_r, sample_rd_s;
  logic                   underrun_r, underrun_s;
  logic                   fall_tick_s;
  logic                   rise_unused_s;

  // Each slot: one delay bit, the sample MSB-first, then zero pad.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [WW-1:0] word);
    logic [SLOT_BITS-1:0] left_slot;
    logic [SLOT_BITS-1:0] right_slot;
    left_slot  = '0;
    right_slot = '0;
    left_slot[SLOT_BITS-2 -: SAMPLE_BITS]  = word[WW-1 -: SAMPLE_BITS];
    right_slot[SLOT_BITS-2 -: SAMPLE_BITS] = word[SAMPLE_BITS-1:0];
    return {left_slot, right_slot};
  endfunction

  i2s_clkgen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_r != RUN),
    .bclk      (bclk),
    .rise_tick (rise_unused_s),
    .fall_tick (fall_tick_s)
  );

  // The FIFO output is only meaningful after a real read; an underrun captures silence.
  assign cap_word_s = zero_r ? {WW{1'b0}} : sample_in;

  // next-state, fetch sequencing and frame shifting
  always_comb begin
    state_s     = state_r;
    fetch_s     = fetch_r;
    bit_cnt_s   = bit_cnt_r;
    shift_s     = shift_r;
    hold_s      = hold_r;
    zero_s      = zero_r;
    lrclk_s     = lrclk_r;
    sample_rd_s = 1'b0;
    underrun_s  = 1'b0;

    case (state_r)
      IDLE: begin
        if (enable) begin
          state_s     = PRIME_REQ;
          sample_rd_s = !sample_empty;
          underrun_s  = sample_empty;
          zero_s      = sample_empty;
        end else begin
          state_s = IDLE;
        end
      end
      PRIME_REQ: begin
        state_s = PRIME_CAP;
      end
      PRIME_CAP: begin
        state_s     = RUN;
        hold_s      = cap_word_s;
        shift_s     = build_frame(cap_word_s);
        bit_cnt_s   = '0;
        lrclk_s     = 1'b0;
        fetch_s     = FETCH_REQ;
        sample_rd_s = !sample_empty;
        underrun_s  = sample_empty;
        zero_s      = sample_empty;
      end
      RUN: begin
        case (fetch_r)
          FETCH_REQ: fetch_s = FETCH_CAP;
          FETCH_CAP: begin
            fetch_s = FETCH_IDLE;
            hold_s  = cap_word_s;
          end
          default:   fetch_s = FETCH_IDLE;
        endcase

        if (fall_tick_s) begin
          if (bit_cnt_r == BCW'(FRAME_BITS - 1)) begin
            if (enable) begin
              shift_s     = build_frame(hold_r);
              bit_cnt_s   = '0;
              lrclk_s     = 1'b0;
              fetch_s     = FETCH_REQ;
              sample_rd_s = !sample_empty;
              underrun_s  = sample_empty;
              zero_s      = sample_empty;
            end else begin
              // Stop at the frame boundary; any prefetched word is dropped.
              state_s   = IDLE;
              shift_s   = '0;
              bit_cnt_s = '0;
              lrclk_s   = 1'b0;
              hold_s    = '0;
              zero_s    = 1'b0;
              fetch_s   = FETCH_IDLE;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 1'b1;
            shift_s   = {shift_r[FRAME_BITS-2:0], 1'b0};
            lrclk_s   = bit_cnt_s[BCW-1];
          end
        end else begin
          bit_cnt_s = bit_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      fetch_r     <= FETCH_IDLE;
      bit_cnt_r   <= '0;
      shift_r     <= '0;
      hold_r      <= '0;
      zero_r      <= 1'b0;
      lrclk_r     <= 1'b0;
      sample_rd_r <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      fetch_r     <= fetch_s;
      bit_cnt_r   <= bit_cnt_s;
      shift_r     <= shift_s;
      hold_r      <= hold_s;
      zero_r      <= zero_s;
      lrclk_r     <= lrclk_s;
      sample_rd_r <= sample_rd_s;
      underrun_r  <= underrun_s;
    end
  end

  assign sample_rd = sample_rd_r;
  assign underrun  = underrun_r;
  assign lrclk     = lrclk_r;
  assign sdata     = shift_r[FRAME_BITS-1];

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: a FIFO model feeds the DUT, expected frames are
// queued by the stimulus, and a monitor rebuilds frames from bclk rising edges.
module tb_i2s_tx;

  localparam int SB  = 24;
  localparam int DIV = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [2*SB-1:0] sample_in = '0;
  logic          sample_empty = 1'b1;
  logic          sample_rd, bclk, lrclk, sdata, underrun;

  logic          wr_en = 1'b0;
  logic [2*SB-1:0] wr_data = '0;
  logic [2*SB-1:0] fifo[$];

  logic [63:0]   exp_q[$];
  int            rd_cycles[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            frames_done = 0;
  int            rd_cnt = 0;
  int            ur_cnt = 0;
  int            mon_bits = 0;
  int            gap = 0;
  logic          bclk_q = 1'b0;
  logic [63:0]   bits = '0;
  logic [63:0]   lrs = '0;

  always #5 clk = ~clk;

  i2s_tx #(.SAMPLE_BITS(SB), .BCLK_DIV(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_empty (sample_empty),
    .sample_rd    (sample_rd),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun)
  );

  // FIFO model: registered read data and registered empty flag
  always @(posedge clk) begin
    if (wr_en) fifo.push_back(wr_data);
    if (sample_rd && fifo.size() != 0) sample_in <= fifo.pop_front();
    sample_empty <= (fifo.size() == 0);
  end

  function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
    return {1'b0, l, 7'b0000000, 1'b0, r, 7'b0000000};
  endfunction

  // monitor: frame reassembly, read/underrun bookkeeping
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sample_rd) begin
      rd_cnt = rd_cnt + 1;
      rd_cycles.push_back(cyc);
      total = total + 1;
      if (sample_empty) begin
        bad = bad + 1;
        $display("FAIL rd_while_empty: sample_rd=1 with sample_empty=%0b at cycle %0d", sample_empty, cyc);
      end
    end
    if (underrun) ur_cnt = ur_cnt + 1;
    if (reset) begin
      mon_bits = 0;
      gap = 0;
    end else if (bclk && !bclk_q) begin
      bits = {bits[62:0], sdata};
      lrs = {lrs[62:0], lrclk};
      mon_bits = mon_bits + 1;
      gap = 0;
      if (mon_bits == 64) begin
        mon_bits = 0;
        frames_done = frames_done + 1;
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL frame_unexpected: got %h want none", bits);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          if (bits !== e) begin
            bad = bad + 1;
            $display("FAIL frame_data %0d: got %h want %h", frames_done, bits, e);
          end
        end
        total = total + 1;
        if (lrs !== 64'h00000000FFFFFFFF) begin
          bad = bad + 1;
          $display("FAIL frame_lrclk %0d: got %h want %h", frames_done, lrs, 64'h00000000FFFFFFFF);
        end
      end
    end else begin
      gap = gap + 1;
      if (gap > 8 * DIV) mon_bits = 0;
    end
    bclk_q = bclk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [2*SB-1:0] w);
    wr_data = w;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (frames_done < target && t < 6000) begin
      @(negedge clk);
      t++;
    end
    if (frames_done < target) chk("frame_timeout", 64'(frames_done), 64'(target));
  endtask

  // keep enable high until the last frame has started, then let it finish
  task automatic run_frames(input int base, input int nfr);
    enable = 1'b1;
    wait_frames(base + nfr - 1);
    repeat (42) @(negedge clk);
    enable = 1'b0;
    wait_frames(base + nfr);
    repeat (40) @(negedge clk);
    chk("idle_bclk", 64'(bclk), 64'd0);
    chk("idle_lrclk", 64'(lrclk), 64'd0);
    chk("idle_sdata", 64'(sdata), 64'd0);
  endtask

  task automatic check_latency(input string name);
    int n;
    n = 0;
    enable = 1'b1;
    while (!bclk && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n), 64'(3 + DIV));
  endtask

  initial begin
    int base;
    int rd0;
    int ur0;
    repeat (3) @(negedge clk);
    chk("rst_bclk", 64'(bclk), 64'd0);
    chk("rst_lrclk", 64'(lrclk), 64'd0);
    chk("rst_sdata", 64'(sdata), 64'd0);
    chk("rst_rd", 64'(sample_rd), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // basic frame plus enable latency
    push_word({24'hABCDEF, 24'h123456});
    exp_q.push_back(64'h55E6F780_091A2B00);
    base = frames_done;
    rd0 = rd_cnt;
    check_latency("latency_first");
    run_frames(base, 1);
    chk("basic_rd_count", 64'(rd_cnt - rd0), 64'd1);

    // streaming: 9 words, 8 frames, last prefetch discarded
    for (int i = 0; i < 9; i++) begin
      logic [23:0] l;
      logic [23:0] r;
      l = 24'h800000 + 24'(i * 24'h010101);
      r = 24'h0F0F0F ^ 24'(i * 24'h111111);
      push_word({l, r});
      if (i < 8) exp_q.push_back(exp_frame(l, r));
    end
    repeat (2) @(negedge clk);
    base = frames_done;
    rd0 = rd_cnt;
    ur0 = ur_cnt;
    rd_cycles.delete();
    run_frames(base, 8);
    chk("stream_rd_count", 64'(rd_cnt - rd0), 64'd9);
    chk("stream_underrun", 64'(ur_cnt - ur0), 64'd0);
    if (rd_cycles.size() == 9) begin
      chk("stream_rd_gap0", 64'(rd_cycles[1] - rd_cycles[0]), 64'd2);
      for (int i = 2; i < 9; i++)
        chk("stream_rd_gap", 64'(rd_cycles[i] - rd_cycles[i-1]), 64'd256);
    end

    // underrun at prime; a word arriving right after appears in frame 2
    base = frames_done;
    rd0 = rd_cnt;
    ur0 = ur_cnt;
    exp_q.push_back(64'd0);
    exp_q.push_back(exp_frame(24'h5A5A5A, 24'hC3C3C3));
    enable = 1'b1;
    for (int t = 0; t < 10 && !underrun; t++) @(negedge clk);
    chk("prime_underrun", 64'(underrun), 64'd1);
    chk("prime_rd", 64'(sample_rd), 64'd0);
    push_word({24'h5A5A5A, 24'hC3C3C3});
    run_frames(base, 2);
    chk("prime_rd_count", 64'(rd_cnt - rd0), 64'd1);
    chk("prime_ur_count", 64'(ur_cnt - ur0), 64'd2);

    // mid-stream underrun: two words, third frame silent; re-enable latency
    push_word({24'h000001, 24'h800000});
    push_word({24'hFFFFFF, 24'h7FFFFE});
    exp_q.push_back(exp_frame(24'h000001, 24'h800000));
    exp_q.push_back(exp_frame(24'hFFFFFF, 24'h7FFFFE));
    exp_q.push_back(64'd0);
    repeat (2) @(negedge clk);
    base = frames_done;
    rd0 = rd_cnt;
    ur0 = ur_cnt;
    check_latency("latency_reenable");
    run_frames(base, 3);
    chk("mid_rd_count", 64'(rd_cnt - rd0), 64'd2);
    chk("mid_ur_count", 64'(ur_cnt - ur0), 64'd2);

    // reset in the middle of a frame
    push_word({24'h246801, 24'h135790});
    repeat (2) @(negedge clk);
    enable = 1'b1;
    for (int t = 0; t < 2000 && mon_bits < 40; t++) @(negedge clk);
    chk("reset_reached_bit40", 64'(mon_bits), 64'd40);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("midrst_bclk", 64'(bclk), 64'd0);
    chk("midrst_lrclk", 64'(lrclk), 64'd0);
    chk("midrst_sdata", 64'(sdata), 64'd0);
    chk("midrst_rd", 64'(sample_rd), 64'd0);
    chk("midrst_underrun", 64'(underrun), 64'd0);
    reset = 1'b0;
    rd0 = rd_cnt;
    repeat (300) @(negedge clk);
    chk("midrst_no_rd", 64'(rd_cnt - rd0), 64'd0);
    chk("midrst_bclk_idle", 64'(bclk), 64'd0);

    chk("frames_left", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
